// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types for the bit-serial adder sequencer
// Contents:
//   serial_st_t : controller state encoding (IDLE -> CALC -> DONE -> IDLE)
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } serial_st_t;

endpackage

// File: rtl/adder_1bit_full.sv
// rtl/adder_1bit_full.sv - combinational 1-bit full adder used as the serial bit slice
// Ports:
//   i_num_a, i_num_b : operand bits
//   i_cry            : carry-in
//   o_res            : sum bit
//   o_cry            : carry-out
module adder_1bit_full (
    input  logic i_num_a,
    input  logic i_num_b,
    input  logic i_cry,
    output logic o_res,
    output logic o_cry
);

    logic half_sum;

    assign half_sum = i_num_a ^ i_num_b;
    assign o_res    = half_sum ^ i_cry;
    assign o_cry    = (i_num_a & i_num_b) | (i_cry & half_sum);

endmodule

// File: rtl/adder_xbit_serial_ctrl.sv
// rtl/adder_xbit_serial_ctrl.sv - bit-serial adder sequencer, LSB-first, one bit per clock
// Ports:
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_flush                    : synchronous abort, overrides both handshakes
//   i_valid / o_ready          : operand handshake (i_num_a, i_num_b, i_cry)
//   o_valid / i_ready          : result handshake (o_res, o_cry)
module adder_xbit_serial_ctrl
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    serial_st_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_sr_q, a_sr_d;
    logic [DATA_WIDTH-1:0] b_sr_q, b_sr_d;
    logic [DATA_WIDTH-1:0] res_sr_q, res_sr_d;
    logic                  cry_q, cry_d;

    logic slice_sum;
    logic slice_cout;

    adder_1bit_full u_slice (
        .i_num_a (a_sr_q[0]),
        .i_num_b (b_sr_q[0]),
        .i_cry   (cry_q),
        .o_res   (slice_sum),
        .o_cry   (slice_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cry_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cry_q    <= cry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cry_d    = cry_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && !i_flush) begin
                    a_sr_d  = i_num_a;
                    b_sr_d  = i_num_b;
                    cry_d   = i_cry;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Sum bits enter at the MSB so that after DATA_WIDTH shifts
                // the first (LSB) sum bit has reached bit 0.
                res_sr_d = {slice_sum, res_sr_q[DATA_WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cry_d    = slice_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything, including an accept in IDLE and a
        // pending result in DONE; datapath contents are left as-is since
        // the next accept reloads them.
        if (i_flush) begin
            state_d = ST_IDLE;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_res   = res_sr_q;
    assign o_cry   = cry_q;

endmodule
